// File: rtl/ibex_pkg.sv
// Shared types for the eFPGA custom-instruction unit: completion modes, FSM states
// and the channel-select width helper.
package ibex_pkg;

    typedef enum logic [1:0] {
        EFPGA_DELAY  = 2'd0,
        EFPGA_DONE   = 2'd1,
        EFPGA_BOTH   = 2'd2,
        EFPGA_EITHER = 2'd3
    } efpga_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } efpga_state_e;

    // A single channel still needs a 1-bit select so out-of-range values exist.
    function automatic int unsigned efpga_sel_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/ibex_efpga_unit_if.sv
// Execute-stage side of the eFPGA unit: instruction request, flush and the
// ready/result/error response. Fabric-side signals stay plain ports on the unit.
interface ibex_efpga_unit_if
    import ibex_pkg::*;
#(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned DELAY_W = 4
);
    localparam int unsigned SEL_W = efpga_sel_w(NUM_CH);

    logic               en_i;
    logic               kill_i;
    efpga_op_e          operator_i;
    logic [SEL_W-1:0]   chan_sel_i;
    logic [DELAY_W-1:0] delay_i;
    logic               ready_o;
    logic               busy_o;
    logic [31:0]        result_o;
    logic               err_o;

    modport master (
        output en_i, kill_i, operator_i, chan_sel_i, delay_i,
        input  ready_o, busy_o, result_o, err_o
    );

    modport slave (
        input  en_i, kill_i, operator_i, chan_sel_i, delay_i,
        output ready_o, busy_o, result_o, err_o
    );

endinterface

// File: rtl/ibex_efpga_result_mux.sv
// Combinational NUM_CH-to-1 selection of 32-bit fabric result channels; a select
// value with no matching channel yields zero.
module ibex_efpga_result_mux #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned SEL_W  = 2
) (
    input  logic [32*NUM_CH-1:0] result_i,
    input  logic [SEL_W-1:0]     sel_i,
    output logic [31:0]          result_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives result_o and no latch is inferred.
        result_o = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (int'(sel_i) == k) begin
                result_o = result_i[32*k +: 32];
            end
        end
    end

endmodule

// File: rtl/ibex_efpga_unit.sv
// eFPGA custom-instruction unit: strobe the fabric, wait for delay/done completion,
// return one result channel. Optional WAIT timeout under IBEX_EFPGA_TIMEOUT_EN.
module ibex_efpga_unit
    import ibex_pkg::*;
#(
    parameter int unsigned NUM_CH         = 3,
    parameter int unsigned DELAY_W        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    ibex_efpga_unit_if.slave     ex,
    output logic                 write_strobe_o,
    input  logic [32*NUM_CH-1:0] result_i,
    input  logic                 efpga_done_i
);

    localparam int unsigned SEL_W = efpga_sel_w(NUM_CH);

    if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("ibex_efpga_unit: NUM_CH must be 1..8 and TIMEOUT_CYCLES at least 1");
    end

    efpga_state_e       state_q, state_d;
    efpga_op_e          op_q;
    logic [SEL_W-1:0]   sel_q;
    logic [DELAY_W-1:0] cnt_q;
    logic [31:0]        result_q;
    logic [31:0]        mux_result;
    logic               dly_zero;
    logic               complete;
    logic               timeout;
    logic               start;
    logic               capture;
    logic               timeout_hit;

    ibex_efpga_result_mux #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_result_mux (
        .result_i (result_i),
        .sel_i    (sel_q),
        .result_o (mux_result)
    );

    assign dly_zero = (cnt_q == '0);

    always_comb begin
        unique case (op_q)
            EFPGA_DELAY:  complete = dly_zero;
            EFPGA_DONE:   complete = efpga_done_i;
            EFPGA_BOTH:   complete = dly_zero & efpga_done_i;
            EFPGA_EITHER: complete = dly_zero | efpga_done_i;
            default:      complete = 1'b0;
        endcase
    end

    // Flush always wins: it blocks both a new start and a capture in the same cycle.
    assign start       = (state_q == IDLE) && ex.en_i && !ex.kill_i;
    assign capture     = (state_q == WAIT) && !ex.kill_i && complete;
    assign timeout_hit = (state_q == WAIT) && !ex.kill_i && !complete && timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ex.en_i) state_d = STROBE;
            STROBE:  state_d = WAIT;
            WAIT:    if (complete || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (ex.kill_i) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        write_strobe_o = (state_q == STROBE);
        ex.ready_o     = (state_q == DONE);
        ex.busy_o      = (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= EFPGA_DELAY;
            sel_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (start) begin
                op_q  <= ex.operator_i;
                sel_q <= ex.chan_sel_i;
                cnt_q <= ex.delay_i;
            end else if ((state_q == WAIT) && !dly_zero) begin
                cnt_q <= cnt_q - DELAY_W'(1);
            end
            if (capture) begin
                result_q <= mux_result;
            end else if (timeout_hit) begin
                result_q <= '0;
            end
        end
    end

    assign ex.result_o = result_q;

`ifdef IBEX_EFPGA_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt_q;
    logic            err_q;

    // Leaving WAIT on the limit keeps the counter from ever wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == WAIT) begin
                wait_cnt_q <= wait_cnt_q + TO_W'(1);
            end else begin
                wait_cnt_q <= '0;
            end
            if (capture) begin
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout  = (wait_cnt_q == TO_W'(TIMEOUT_CYCLES));
    assign ex.err_o = err_q;
`else
    assign timeout  = 1'b0;
    assign ex.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_efpga_unit.sv
// Directed bench for ibex_efpga_unit: completion modes, kill, timeout or endless
// WAIT, single-channel out-of-range select and asynchronous reset.
module tb_ibex_efpga_unit;
    import ibex_pkg::*;

    logic        clk;
    logic        rst;
    logic        done;
    logic [95:0] res0;
    logic [31:0] res1;
    logic        strobe0, strobe1;
    int          n_tests;
    int          n_fail;

    ibex_efpga_unit_if #(.NUM_CH(3), .DELAY_W(4)) ex0 ();
    ibex_efpga_unit_if #(.NUM_CH(1), .DELAY_W(4)) ex1 ();

    ibex_efpga_unit #(.NUM_CH(3), .DELAY_W(4), .TIMEOUT_CYCLES(4)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .ex             (ex0),
        .write_strobe_o (strobe0),
        .result_i       (res0),
        .efpga_done_i   (done)
    );

    ibex_efpga_unit #(.NUM_CH(1), .DELAY_W(4), .TIMEOUT_CYCLES(4)) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .ex             (ex1),
        .write_strobe_o (strobe1),
        .result_i       (res1),
        .efpga_done_i   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic kill, input efpga_op_e op,
                         input int sel, input int dly);
        ex0.en_i       = en;
        ex0.kill_i     = kill;
        ex0.operator_i = op;
        ex0.chan_sel_i = 2'(sel);
        ex0.delay_i    = 4'(dly);
        ex1.en_i       = en;
        ex1.kill_i     = kill;
        ex1.operator_i = op;
        ex1.chan_sel_i = 1'(sel);
        ex1.delay_i    = 4'(dly);
    endtask

    // Cycle c: outputs observed at the negedge, then inputs for cycle c applied.
    task automatic run_op(input string tag, input bit which, input efpga_op_e op,
                          input int sel, input int dly, input logic [63:0] done_mask,
                          input int kill_cyc, input int ncyc, input int exp_strobes,
                          input int exp_ready, input logic [31:0] exp_res,
                          input logic exp_err, input int busy_cyc, input logic exp_busy);
        int   ready_cyc  = -1;
        int   strobe_cyc = -1;
        int   n_strobe   = 0;
        logic busy_seen  = 1'bx;
        bit   active     = 1'b1;
        logic g_strobe, g_ready, g_busy, g_err;
        logic [31:0] g_res;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            g_strobe = which ? strobe1 : strobe0;
            g_ready  = which ? ex1.ready_o : ex0.ready_o;
            g_busy   = which ? ex1.busy_o : ex0.busy_o;
            if (g_strobe) begin
                n_strobe++;
                if (strobe_cyc < 0) strobe_cyc = c;
            end
            if (g_ready && ready_cyc < 0) ready_cyc = c;
            if (c == busy_cyc) busy_seen = g_busy;
            if (ready_cyc >= 0 || (kill_cyc >= 0 && c > kill_cyc)) active = 1'b0;
            drive(active, c == kill_cyc, op, sel, dly);
            done = done_mask[c];
        end
        drive(1'b0, 1'b0, EFPGA_DELAY, 0, 0);
        done  = 1'b0;
        g_res = which ? ex1.result_o : ex0.result_o;
        g_err = which ? ex1.err_o : ex0.err_o;
        check({tag, "_nstrobe"}, n_strobe, exp_strobes);
        if (exp_strobes > 0) check({tag, "_strobe_cyc"}, strobe_cyc, 1);
        check({tag, "_ready_cyc"}, ready_cyc, exp_ready);
        check({tag, "_result"}, g_res, exp_res);
        check({tag, "_err"}, {31'd0, g_err}, {31'd0, exp_err});
        if (busy_cyc >= 0) check({tag, "_busy"}, {31'd0, busy_seen}, {31'd0, exp_busy});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        done    = 1'b0;
        res0    = {32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
        res1    = 32'hCAFE_F00D;
        drive(1'b0, 1'b0, EFPGA_DELAY, 0, 0);

        #3;
        check("rst_strobe", {31'd0, strobe0}, 32'd0);
        check("rst_ready", {31'd0, ex0.ready_o}, 32'd0);
        check("rst_busy", {31'd0, ex0.busy_o}, 32'd0);
        check("rst_result", ex0.result_o, 32'h0);
        check("rst_err", {31'd0, ex0.err_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // tag, dut, op, sel, dly, done mask, kill, ncyc, strobes, ready, result, err, busy cyc/exp
        run_op("m0_d5", 0, EFPGA_DELAY, 2, 5, 64'h0, -1, 11, 1, 8, 32'hDEAD_BEEF, 1'b0, 5, 1'b1);
        run_op("m1_done4", 0, EFPGA_DONE, 0, 15, 64'h32, -1, 8, 1, 5, 32'h1111_1111, 1'b0, 3, 1'b1);
        run_op("m2_both", 0, EFPGA_BOTH, 1, 3, 64'h1C04, -1, 14, 1, 11, 32'h2222_2222, 1'b0, 6, 1'b1);
        res0[63:32] = 32'h3333_3333;
        run_op("m3_either", 0, EFPGA_EITHER, 1, 3, 64'h1C04, -1, 6, 1, 3, 32'h3333_3333, 1'b0, -1, 1'b0);

        res0[31:0] = 32'hAAAA_5555;
        run_op("kill_wait", 0, EFPGA_DELAY, 0, 5, 64'h0, 3, 12, 1, -1, 32'h3333_3333, 1'b0, 4, 1'b0);
        run_op("kill_idle", 0, EFPGA_DELAY, 0, 5, 64'h0, 0, 5, 0, -1, 32'h3333_3333, 1'b0, 1, 1'b0);

`ifdef IBEX_EFPGA_TIMEOUT_EN
        run_op("timeout", 0, EFPGA_DONE, 0, 0, 64'h0, -1, 10, 1, 7, 32'h0, 1'b1, 4, 1'b1);
        run_op("after_to", 0, EFPGA_DELAY, 2, 0, 64'h0, -1, 6, 1, 3, 32'hDEAD_BEEF, 1'b0, -1, 1'b0);
`else
        run_op("no_timeout", 0, EFPGA_DONE, 0, 0, 64'h0, 40, 44, 1, -1, 32'h3333_3333, 1'b0, 39, 1'b1);
`endif

        run_op("ch1_sel0", 1, EFPGA_DELAY, 0, 0, 64'h0, -1, 6, 1, 3, 32'hCAFE_F00D, 1'b0, -1, 1'b0);
        run_op("ch1_sel1", 1, EFPGA_DELAY, 1, 0, 64'h0, -1, 6, 1, 3, 32'h0, 1'b0, -1, 1'b0);

        // Last dut0 capture was channel 1, so result_o is non-zero before the reset.
        @(negedge clk);
        drive(1'b1, 1'b0, EFPGA_DELAY, 2, 10);
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {31'd0, ex0.busy_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_strobe", {31'd0, strobe0}, 32'd0);
        check("arst_ready", {31'd0, ex0.ready_o}, 32'd0);
        check("arst_busy", {31'd0, ex0.busy_o}, 32'd0);
        check("arst_result", ex0.result_o, 32'h0);
        check("arst_err", {31'd0, ex0.err_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, EFPGA_DELAY, 0, 0);
        run_op("post_rst", 0, EFPGA_DELAY, 2, 2, 64'h0, -1, 8, 1, 5, 32'hDEAD_BEEF, 1'b0, 3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
